// File: rtl/matrix_tile_sequencer.sv
// Streams 2x2 operand tiles from the weight RAM into the ALU, waits out the ALU
// latency, then writes the four product words of each tile to the result buffer.
module matrix_tile_sequencer #(
  parameter int NUM_TILES   = 8,
  parameter int MEM_AW      = 6,
  parameter int RES_AW      = 5,
  parameter int ALU_LATENCY = 1,
  localparam int TILE_W     = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [15:0]       ID_instr,
  output logic [31:0]       matrixA_11,
  output logic [31:0]       matrixA_12,
  output logic [31:0]       matrixA_21,
  output logic [31:0]       matrixA_22,
  output logic [31:0]       matrixB_11,
  output logic [31:0]       matrixB_12,
  output logic [31:0]       matrixB_21,
  output logic [31:0]       matrixB_22,
  input  logic [31:0]       matrixp00,
  input  logic [31:0]       matrixp01,
  input  logic [31:0]       matrixp10,
  input  logic [31:0]       matrixp11,
  output logic              res_wr_en,
  output logic [RES_AW-1:0] res_addr,
  output logic [31:0]       res_wdata,
  output logic [TILE_W-1:0] tile_idx,
  output logic [31:0]       total_cycles
);

  localparam int WAIT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_STORE,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [3:0]        k;
  logic [1:0]        j;
  logic [WAIT_W-1:0] wcnt;
  logic [31:0]       opnd [8];
  logic [31:0]       hold [4];
  logic              wait_last;
  logic              last_tile;

  assign wait_last = (wcnt == WAIT_W'(ALU_LATENCY - 1));
  assign last_tile = (tile_idx == TILE_W'(NUM_TILES - 1));

  assign matrixA_11 = opnd[0];
  assign matrixA_12 = opnd[1];
  assign matrixA_21 = opnd[2];
  assign matrixA_22 = opnd[3];
  assign matrixB_11 = opnd[4];
  assign matrixB_12 = opnd[5];
  assign matrixB_21 = opnd[6];
  assign matrixB_22 = opnd[7];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Strobes and addresses are decoded straight from the state so a reset lands
  // every control output at zero on the same edge that forces IDLE.
  always_comb begin
    state_nx  = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    ID_instr  = 16'd0;
    res_wr_en = 1'b0;
    res_addr  = '0;
    res_wdata = '0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_FETCH;
      end
      S_FETCH: begin
        busy = 1'b1;
        if (!k[3]) begin
          mem_rd_en = 1'b1;
          mem_addr  = MEM_AW'({tile_idx, k[2:0]});
        end else begin
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy     = 1'b1;
        ID_instr = 16'd1;
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (wait_last) state_nx = S_STORE;
      end
      S_STORE: begin
        busy      = 1'b1;
        res_wr_en = 1'b1;
        res_addr  = RES_AW'({tile_idx, j});
        res_wdata = hold[j];
        if (j == 2'd3) state_nx = last_tile ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k            <= '0;
      j            <= '0;
      wcnt         <= '0;
      tile_idx     <= '0;
      total_cycles <= '0;
      for (int i = 0; i < 8; i++) opnd[i] <= '0;
      for (int i = 0; i < 4; i++) hold[i] <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        tile_idx     <= '0;
        total_cycles <= '0;
      end else if (busy) begin
        total_cycles <= total_cycles + 32'd1;
      end
      case (state)
        S_FETCH: begin
          // RAM data lags the read by one cycle, so count k lands word k-1;
          // at k=8 the index wraps to 7 for the final B_22 word.
          k <= k[3] ? 4'd0 : k + 4'd1;
          if (k != 4'd0) opnd[k[2:0] - 3'd1] <= mem_rdata;
        end
        S_WAIT: begin
          wcnt <= wait_last ? '0 : wcnt + WAIT_W'(1);
          if (wait_last) begin
            hold[0] <= matrixp00;
            hold[1] <= matrixp01;
            hold[2] <= matrixp10;
            hold[3] <= matrixp11;
          end
        end
        S_STORE: begin
          j <= j + 2'd1;
          if (j == 2'd3 && !last_tile) tile_idx <= tile_idx + TILE_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
